// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the arbiter state encoding.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY     = 2'd1,
    ARB_ERR_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first asserted req scanning ptr, ptr+1, .. mod N.
module rr_priority_sel #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW:0] w_idx;
  logic        w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // One spare bit holds ptr+i before folding back into 0..N-1.
      w_idx = {1'b0, ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!w_found && req[w_idx[PW-1:0]]) begin
        gnt[w_idx[PW-1:0]] = 1'b1;
        w_found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port between N masters,
// with whole-cycle ownership, owner-only ack/err routing and a stuck-transfer timeout.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTERS      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rstn_i,
  input  logic [N_MASTERS-1:0]         m_cyc_i,
  input  logic [N_MASTERS-1:0]         m_stb_i,
  input  logic [N_MASTERS-1:0]         m_we_i,
  input  logic [WB_SELW*N_MASTERS-1:0] m_sel_i,
  input  logic [WB_AW*N_MASTERS-1:0]   m_adr_i,
  input  logic [WB_DW*N_MASTERS-1:0]   m_dat_i,
  output logic [WB_DW-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]         m_ack_o,
  output logic [N_MASTERS-1:0]         m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [WB_SELW-1:0]           s_sel_o,
  output logic [WB_AW-1:0]             s_adr_o,
  output logic [WB_DW-1:0]             s_dat_o,
  input  logic [WB_DW-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [N_MASTERS-1:0]         grant_o,
  output logic                         timeout_o
);

  localparam int PW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t             r_state, r_state_next;
  logic [N_MASTERS-1:0]   r_grant, r_grant_next;
  logic [PW-1:0]          r_ptr, r_ptr_next;
  logic [CW-1:0]          r_cnt, r_cnt_next;

  logic [N_MASTERS-1:0]   w_gnt;
  logic [PW-1:0]          w_sel_ptr, w_owner, w_rel_ptr;
  logic                   w_own_cyc, w_own_stb, w_own_we, w_busy, w_tmo_hit;
  logic [WB_SELW-1:0]     w_own_sel;
  logic [WB_AW-1:0]       w_own_adr;
  logic [WB_DW-1:0]       w_own_dat;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_next;
      r_grant <= r_grant_next;
      r_ptr   <= r_ptr_next;
      r_cnt   <= r_cnt_next;
    end
  end

  always_comb begin
    w_owner   = '0;
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_sel = '0;
    w_own_adr = '0;
    w_own_dat = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_owner   = PW'(k);
        w_own_cyc = m_cyc_i[k];
        w_own_stb = m_stb_i[k];
        w_own_we  = m_we_i[k];
        w_own_sel = m_sel_i[k*WB_SELW +: WB_SELW];
        w_own_adr = m_adr_i[k*WB_AW +: WB_AW];
        w_own_dat = m_dat_i[k*WB_DW +: WB_DW];
      end
    end
  end

  assign w_rel_ptr = (w_owner == PW'(N_MASTERS - 1)) ? '0 : w_owner + PW'(1);
  // A release scans from the departing owner's successor, an idle grant from the stored pointer.
  assign w_sel_ptr = (r_state == ARB_IDLE) ? r_ptr : w_rel_ptr;

  rr_priority_sel #(
    .N  (N_MASTERS),
    .PW (PW)
  ) u_sel (
    .req (m_cyc_i),
    .ptr (w_sel_ptr),
    .gnt (w_gnt)
  );

  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES)) &&
                     w_own_stb && !s_ack_i && !s_err_i;

  always_comb begin
    r_state_next = r_state;
    r_grant_next = r_grant;
    r_ptr_next   = r_ptr;
    r_cnt_next   = '0;
    m_ack_o      = '0;
    m_err_o      = '0;
    timeout_o    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          r_grant_next = w_gnt;
          r_state_next = ARB_BUSY;
        end
      end
      ARB_BUSY, ARB_ERR_WAIT: begin
        if (!w_own_cyc) begin
          r_ptr_next   = w_rel_ptr;
          r_grant_next = w_gnt;
          r_state_next = (|m_cyc_i) ? ARB_BUSY : ARB_IDLE;
        end else if (r_state == ARB_BUSY) begin
          m_err_o = r_grant & {N_MASTERS{s_err_i}};
          m_ack_o = r_grant & {N_MASTERS{s_ack_i & ~s_err_i}};
          if (w_tmo_hit) begin
            m_err_o      = r_grant;
            timeout_o    = 1'b1;
            r_state_next = ARB_ERR_WAIT;
          end else if (w_own_stb && !s_ack_i && !s_err_i) begin
            r_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        r_state_next = ARB_IDLE;
        r_grant_next = '0;
      end
    endcase
  end

  assign w_busy    = (r_state == ARB_BUSY);
  assign s_cyc_o   = w_busy & w_own_cyc;
  assign s_stb_o   = w_busy & w_own_cyc & w_own_stb;
  assign s_we_o    = w_busy & w_own_we;
  assign s_sel_o   = w_busy ? w_own_sel : '0;
  assign s_adr_o   = w_busy ? w_own_adr : '0;
  assign s_dat_o   = w_busy ? w_own_dat : '0;
  assign m_dat_o   = w_busy ? s_dat_i : '0;
  assign grant_o   = r_grant;

endmodule
